// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: per-channel synchroniser, stability counter and result register.
// Define DEBOUNCE_EDGE_EN to build the registered one-cycle rise/fall pulses; otherwise they are tied to 0.
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] result,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam bit              SINGLE   = (STABLE_CYCLES == 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    state_t                 state_r;
    logic                   result_r;
    logic                   s_s;
    logic                   upd_s;

    assign s_s = sync_r[SYNC_STAGES-1];
    // A result update happens when the mismatch has lasted the full stability window.
    assign upd_s = (s_s != result_r) &&
                   ((state_r == ST_STABLE) ? SINGLE : (cnt_r == CNT_LAST));

    // Input synchroniser chain for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], button[i]};
      end
    end

    // Stability FSM: any mismatch run shorter than the window is discarded.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r  <= ST_STABLE;
        cnt_r    <= CNT_ZERO;
        result_r <= 1'b0;
      end else begin
        case (state_r)
          ST_STABLE: begin
            if (upd_s) begin
              result_r <= s_s;
            end else if (s_s != result_r) begin
              cnt_r   <= CNT_ONE;
              state_r <= ST_PENDING;
            end else begin
              cnt_r   <= CNT_ZERO;
            end
          end
          ST_PENDING: begin
            if (upd_s) begin
              result_r <= s_s;
              cnt_r    <= CNT_ZERO;
              state_r  <= ST_STABLE;
            end else if (s_s == result_r) begin
              cnt_r    <= CNT_ZERO;
              state_r  <= ST_STABLE;
            end else begin
              cnt_r    <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_STABLE;
          end
        endcase
      end
    end

    assign result[i] = result_r;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_r;
    logic fall_r;

    // Edge pulses coincide with the edge at which result changes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        rise_r <= upd_s & s_s;
        fall_r <= upd_s & ~s_s;
      end
    end

    assign rise[i] = rise_r;
    assign fall[i] = fall_r;
`else
    assign rise[i] = 1'b0;
    assign fall[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (CHANNELS=4, STABLE_CYCLES=4, SYNC_STAGES=2).
// Edge-pulse expectations follow DEBOUNCE_EDGE_EN; without it rise/fall must stay 0.
module tb_debounce_multi;

  logic       clk;
  logic       rst;
  logic [3:0] button;
  logic [3:0] result;
  logic [3:0] rise;
  logic [3:0] fall;

  int tests_run;
  int tests_failed;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  debounce_multi #(
    .CHANNELS(4),
    .STABLE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .result(result),
    .rise(rise),
    .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ep(input logic [3:0] v);
    return EDGE ? v : 4'h0;
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle_low();
    button = 4'h0;
    tick(8);
    tests_run++;
    if (result !== 4'h0) begin
      tests_failed++;
      $display("FAIL settle_low: result=%h expected=%h", result, 4'h0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    button = 4'hF;
    tick(5);
    tests_run++;
    if ({result, rise, fall} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_hold: result=%h rise=%h fall=%h expected all 0", result, rise, fall);
    end
    rst = 1'b0;
    tick(5);
    tests_run++;
    if (result !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_release_early: result=%h expected=%h", result, 4'h0);
    end
    tick(1);
    tests_run++;
    if (result !== 4'hF || rise !== ep(4'hF)) begin
      tests_failed++;
      $display("FAIL reset_release_e5: result=%h rise=%h expected %h/%h", result, rise, 4'hF, ep(4'hF));
    end
    settle_low();
  endtask

  task automatic test_clean_press();
    button = 4'h1;
    tick(5);
    tests_run++;
    if (result !== 4'h0 || rise !== 4'h0) begin
      tests_failed++;
      $display("FAIL press_early: result=%h rise=%h expected 0/0", result, rise);
    end
    tick(1);
    tests_run++;
    if (result !== 4'h1 || rise !== ep(4'h1) || fall !== 4'h0) begin
      tests_failed++;
      $display("FAIL press_e5: result=%h rise=%h fall=%h expected %h/%h/0", result, rise, fall, 4'h1, ep(4'h1));
    end
    tick(1);
    tests_run++;
    if (result !== 4'h1 || rise !== 4'h0) begin
      tests_failed++;
      $display("FAIL press_pulse_end: result=%h rise=%h expected 1/0", result, rise);
    end
    button = 4'h0;
    tick(5);
    tests_run++;
    if (result !== 4'h1 || fall !== 4'h0) begin
      tests_failed++;
      $display("FAIL release_early: result=%h fall=%h expected 1/0", result, fall);
    end
    tick(1);
    tests_run++;
    if (result !== 4'h0 || fall !== ep(4'h1) || rise !== 4'h0) begin
      tests_failed++;
      $display("FAIL release_e5: result=%h fall=%h rise=%h expected 0/%h/0", result, fall, rise, ep(4'h1));
    end
    tick(1);
    tests_run++;
    if (fall !== 4'h0) begin
      tests_failed++;
      $display("FAIL release_pulse_end: fall=%h expected 0", fall);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int bad;
    pat = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      button = {2'b00, pat[k], 1'b0};
      tick(1);
      if (result !== 4'h0 || rise !== 4'h0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bounce_quiet: %0d cycles with output change, expected 0", bad);
    end
    tick(4);
    tests_run++;
    if (result !== 4'h0) begin
      tests_failed++;
      $display("FAIL bounce_early: result=%h expected=%h", result, 4'h0);
    end
    tick(1);
    tests_run++;
    if (result !== 4'h2 || rise !== ep(4'h2)) begin
      tests_failed++;
      $display("FAIL bounce_e5: result=%h rise=%h expected %h/%h", result, rise, 4'h2, ep(4'h2));
    end
    tick(1);
    tests_run++;
    if (rise !== 4'h0) begin
      tests_failed++;
      $display("FAIL bounce_single_pulse: rise=%h expected 0", rise);
    end
    settle_low();
  endtask

  task automatic test_parallel();
    button = 4'hD;
    tick(2);
    button = 4'hC;
    tick(3);
    tests_run++;
    if (result !== 4'h0) begin
      tests_failed++;
      $display("FAIL parallel_early: result=%h expected=%h", result, 4'h0);
    end
    tick(1);
    tests_run++;
    if (result !== 4'hC || rise !== ep(4'hC)) begin
      tests_failed++;
      $display("FAIL parallel_e5: result=%h rise=%h expected %h/%h", result, rise, 4'hC, ep(4'hC));
    end
    tick(4);
    tests_run++;
    if (result !== 4'hC) begin
      tests_failed++;
      $display("FAIL parallel_glitch_ch0: result=%h expected=%h", result, 4'hC);
    end
    settle_low();
  endtask

  task automatic test_reset_mid();
    button = 4'h2;
    tick(4);  // two cycles into PENDING
    rst = 1'b1;
    tick(1);
    tests_run++;
    if (result !== 4'h0 || rise !== 4'h0) begin
      tests_failed++;
      $display("FAIL midrst_hold: result=%h rise=%h expected 0/0", result, rise);
    end
    rst = 1'b0;
    tick(5);
    tests_run++;
    if (result !== 4'h0) begin
      tests_failed++;
      $display("FAIL midrst_early: result=%h expected=%h", result, 4'h0);
    end
    tick(1);
    tests_run++;
    if (result !== 4'h2 || rise !== ep(4'h2)) begin
      tests_failed++;
      $display("FAIL midrst_e5: result=%h rise=%h expected %h/%h", result, rise, 4'h2, ep(4'h2));
    end
    settle_low();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    button = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_parallel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
